// File: rtl/pc_control_tmr_pkg.sv
// Shared definitions for the fault-tolerant fetch program counter.
// Holds the default parameter values, the run/error state encodings and a small
// alignment helper. The rest of the block imports these definitions.
package pc_control_tmr_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned INC_DEF       = 4;
  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] TRAP_VEC_DEF  = 32'h0000_0100;
  localparam int unsigned FCNT_W_DEF    = 8;
  localparam int unsigned INJ_BIT_DEF   = 2;

  // Two-state FSM encodings. ERROR is left only through reset.
  localparam logic [0:0] StRun   = 1'b0;
  localparam logic [0:0] StError = 1'b1;

  // A fetch target is usable only when it is word aligned.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/pc_control_tmr_voter3.sv
// Bitwise triple-modular-redundancy voter.
// Ports:
//   a_i, b_i, c_i  : the three redundant copies
//   maj_o          : bitwise two-of-three majority
//   mismatch_o[i]  : copy i differs from the majority
//   all_differ_o   : no two copies are equal (word level), so the vote cannot be trusted
module pc_control_tmr_voter3 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] c_i,
  output logic [W-1:0] maj_o,
  output logic [2:0]   mismatch_o,
  output logic         all_differ_o
);

  always_comb begin
    maj_o         = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
    mismatch_o[0] = (a_i != maj_o);
    mismatch_o[1] = (b_i != maj_o);
    mismatch_o[2] = (c_i != maj_o);
    all_differ_o  = (a_i != b_i) && (b_i != c_i) && (a_i != c_i);
  end

endmodule

// File: rtl/pc_control_tmr.sv
// Fault-tolerant fetch program counter with three redundant PC copies.
// The output PC is the majority vote of the copies; every non-reset edge in RUN all
// copies are rewritten with the next PC, which scrubs any single-copy upset.
// Ports:
//   clk_i            : rising-edge clock
//   reset_i          : synchronous active-high reset
//   trap_req_i       : force PC to TRAP_VEC
//   pc_redirect_i    : load redirect_addr_i (branch/jump/flush)
//   redirect_addr_i  : redirect target; misaligned targets trap instead
//   pc_hold_i        : stall, keep the current PC
//   fault_inject_i   : test hook, bit i flips INJ_BIT of copy i on this edge
//   pc_o             : voted PC (combinational)
//   pc_valid_o       : PC usable by fetch
//   misalign_trap_o  : one-cycle pulse after a misaligned redirect was trapped
//   fault_detected_o : some copy disagrees with the voted value
//   fault_count_o    : saturating count of cycles with fault_detected_o set
//   uncorrectable_o  : sticky, no two copies agreed; core must stop
module pc_control_tmr
  import pc_control_tmr_pkg::*;
#(
  parameter int unsigned    XLEN      = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(TRAP_VEC_DEF),
  parameter int unsigned    INC       = INC_DEF,
  parameter int unsigned    FCNT_W    = FCNT_W_DEF,
  parameter int unsigned    INJ_BIT   = INJ_BIT_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              trap_req_i,
  input  logic              pc_redirect_i,
  input  logic [XLEN-1:0]   redirect_addr_i,
  input  logic              pc_hold_i,
  input  logic [2:0]        fault_inject_i,
  output logic [XLEN-1:0]   pc_o,
  output logic              pc_valid_o,
  output logic              misalign_trap_o,
  output logic              fault_detected_o,
  output logic [FCNT_W-1:0] fault_count_o,
  output logic              uncorrectable_o
);

  localparam logic [XLEN-1:0] InjMask = XLEN'(1) << INJ_BIT;
  localparam logic [XLEN-1:0] IncVal  = XLEN'(INC);

  logic [XLEN-1:0]   c0_q, c1_q, c2_q;
  logic [XLEN-1:0]   c0_d, c1_d, c2_d;
  logic [XLEN-1:0]   voted;
  logic [2:0]        mismatch;
  logic              all_differ;
  logic [XLEN-1:0]   next_pc;
  logic              redir_misalign;
  logic [0:0]        state_q, state_d;
  logic              pc_valid_q;
  logic              misalign_q, misalign_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              copy_upd;

  pc_control_tmr_voter3 #(
    .W (XLEN)
  ) u_voter (
    .a_i          (c0_q),
    .b_i          (c1_q),
    .c_i          (c2_q),
    .maj_o        (voted),
    .mismatch_o   (mismatch),
    .all_differ_o (all_differ)
  );

  // Next-PC priority: trap > misaligned redirect > redirect > hold > increment.
  always_comb begin
    next_pc        = voted + IncVal;
    redir_misalign = 1'b0;
    if (trap_req_i) begin
      next_pc = TRAP_VEC;
    end else if (pc_redirect_i && misaligned(redirect_addr_i[1:0])) begin
      next_pc        = TRAP_VEC;
      redir_misalign = 1'b1;
    end else if (pc_redirect_i) begin
      next_pc = redirect_addr_i;
    end else if (pc_hold_i) begin
      next_pc = voted;
    end
  end

  always_comb begin
    c0_d = next_pc ^ (fault_inject_i[0] ? InjMask : '0);
    c1_d = next_pc ^ (fault_inject_i[1] ? InjMask : '0);
    c2_d = next_pc ^ (fault_inject_i[2] ? InjMask : '0);
  end

  // Copies are frozen from the lockout edge on, so the failing state stays observable.
  always_comb begin
    copy_upd   = (state_q == StRun) && !all_differ;
    state_d    = (state_q == StRun && all_differ) ? StError : state_q;
    misalign_d = copy_upd && redir_misalign;
    fcnt_d     = fcnt_q;
    if (state_q == StRun && fault_detected_o && fcnt_q != {FCNT_W{1'b1}}) begin
      fcnt_d = fcnt_q + FCNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      c0_q       <= RESET_VEC;
      c1_q       <= RESET_VEC;
      c2_q       <= RESET_VEC;
      state_q    <= StRun;
      pc_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      fcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      pc_valid_q <= (state_d == StRun);
      misalign_q <= misalign_d;
      fcnt_q     <= fcnt_d;
      if (copy_upd) begin
        c0_q <= c0_d;
        c1_q <= c1_d;
        c2_q <= c2_d;
      end
    end
  end

  assign pc_o             = voted;
  assign pc_valid_o       = pc_valid_q;
  assign misalign_trap_o  = misalign_q;
  assign fault_detected_o = |mismatch;
  assign fault_count_o    = fcnt_q;
  assign uncorrectable_o  = (state_q == StError);

endmodule

// File: tb/tb_pc_control_tmr.sv
// Directed bench for pc_control_tmr: reset, sequencing, hold/redirect/trap priority,
// fault masking and counting, counter saturation, PC wrap and the lockout state.
module tb_pc_control_tmr;

  logic        clk = 1'b0;
  logic        reset;
  logic        trap_req;
  logic        pc_redirect;
  logic [31:0] redirect_addr;
  logic        pc_hold;
  logic [2:0]  fault_inject;
  logic [31:0] pc;
  logic        pc_valid;
  logic        misalign_trap;
  logic        fault_detected;
  logic [7:0]  fault_count;
  logic        uncorrectable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pc_control_tmr dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .trap_req_i       (trap_req),
    .pc_redirect_i    (pc_redirect),
    .redirect_addr_i  (redirect_addr),
    .pc_hold_i        (pc_hold),
    .fault_inject_i   (fault_inject),
    .pc_o             (pc),
    .pc_valid_o       (pc_valid),
    .misalign_trap_o  (misalign_trap),
    .fault_detected_o (fault_detected),
    .fault_count_o    (fault_count),
    .uncorrectable_o  (uncorrectable)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock edge, then sample on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    trap_req      = 1'b0;
    pc_redirect   = 1'b0;
    redirect_addr = 32'h0;
    pc_hold       = 1'b0;
    fault_inject  = 3'b000;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    @(negedge clk);
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_valid", {31'h0, pc_valid}, 32'h0);
    check("rst_misalign", {31'h0, misalign_trap}, 32'h0);
    check("rst_fcnt", {24'h0, fault_count}, 32'h0);
    check("rst_uncorr", {31'h0, uncorrectable}, 32'h0);
    check("rst_fdet", {31'h0, fault_detected}, 32'h0);

    // Sequential fetch.
    reset = 1'b0;
    check("rel_pc0", pc, 32'h0);
    step();
    check("seq_pc4", pc, 32'h4);
    check("seq_valid", {31'h0, pc_valid}, 32'h1);
    step();
    check("seq_pc8", pc, 32'h8);
    step();
    check("seq_pcc", pc, 32'hC);

    // Hold two cycles, then redirect beats hold.
    pc_hold = 1'b1;
    step();
    check("hold1", pc, 32'hC);
    step();
    check("hold2", pc, 32'hC);
    pc_redirect   = 1'b1;
    redirect_addr = 32'h20;
    step();
    check("redir_over_hold", pc, 32'h20);
    check("redir_no_misal", {31'h0, misalign_trap}, 32'h0);

    // Misaligned redirect traps and pulses for one cycle.
    pc_hold       = 1'b0;
    redirect_addr = 32'h22;
    step();
    check("misal_pc", pc, 32'h100);
    check("misal_pulse", {31'h0, misalign_trap}, 32'h1);
    idle_inputs();
    step();
    check("misal_after_pc", pc, 32'h104);
    check("misal_pulse_end", {31'h0, misalign_trap}, 32'h0);

    // Trap beats redirect.
    trap_req      = 1'b1;
    pc_redirect   = 1'b1;
    redirect_addr = 32'h40;
    step();
    check("trap_pc", pc, 32'h100);
    check("trap_no_misal", {31'h0, misalign_trap}, 32'h0);

    // Get to 0x10, then corrupt copy 0 for one edge.
    idle_inputs();
    pc_redirect   = 1'b1;
    redirect_addr = 32'h10;
    step();
    check("to_0x10", pc, 32'h10);
    idle_inputs();
    fault_inject = 3'b001;
    step();
    check("inj1_pc", pc, 32'h14);
    check("inj1_fdet", {31'h0, fault_detected}, 32'h1);
    check("inj1_fcnt0", {24'h0, fault_count}, 32'h0);
    fault_inject = 3'b000;
    step();
    check("scrub_pc", pc, 32'h18);
    check("scrub_fdet", {31'h0, fault_detected}, 32'h0);
    check("scrub_fcnt", {24'h0, fault_count}, 32'h1);

    // Two copies corrupted equally: vote follows them, no lockout.
    fault_inject = 3'b011;
    step();
    check("inj2_pc", pc, 32'h18);
    check("inj2_fdet", {31'h0, fault_detected}, 32'h1);
    check("inj2_uncorr", {31'h0, uncorrectable}, 32'h0);
    check("inj2_valid", {31'h0, pc_valid}, 32'h1);
    fault_inject = 3'b000;
    step();
    check("inj2_next_pc", pc, 32'h1C);
    check("inj2_fcnt", {24'h0, fault_count}, 32'h2);

    // Wrap at the top of the address space.
    pc_redirect   = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    step();
    check("wrap_top", pc, 32'hFFFF_FFFC);
    idle_inputs();
    step();
    check("wrap_zero", pc, 32'h0);
    step();
    check("wrap_four", pc, 32'h4);

    // Continuous upset on copy 0: counter climbs to 0xFE, then saturates.
    fault_inject = 3'b001;
    repeat (253) step();
    check("sat_fe", {24'h0, fault_count}, 32'hFE);
    check("sat_fdet", {31'h0, fault_detected}, 32'h1);
    repeat (3) step();
    check("sat_ff", {24'h0, fault_count}, 32'hFF);
    check("sat_pc_masked", pc, 32'h404);
    fault_inject = 3'b000;
    step();
    check("sat_hold_ff", {24'h0, fault_count}, 32'hFF);
    check("sat_clean_pc", pc, 32'h408);
    check("sat_clean_fdet", {31'h0, fault_detected}, 32'h0);

    // Three distinct copies: lockout.
    force dut.c0_q = 32'h1000;
    force dut.c1_q = 32'h2000;
    force dut.c2_q = 32'h3000;
    #1;
    check("lock_pre_pc", pc, 32'h3000);
    check("lock_pre_fdet", {31'h0, fault_detected}, 32'h1);
    step();
    release dut.c0_q;
    release dut.c1_q;
    release dut.c2_q;
    #1;
    check("lock_uncorr", {31'h0, uncorrectable}, 32'h1);
    check("lock_valid", {31'h0, pc_valid}, 32'h0);
    check("lock_pc", pc, 32'h3000);

    // Inputs ignored while locked.
    trap_req      = 1'b1;
    pc_redirect   = 1'b1;
    redirect_addr = 32'h42;
    fault_inject  = 3'b111;
    step();
    step();
    check("err_pc_frozen", pc, 32'h3000);
    check("err_uncorr", {31'h0, uncorrectable}, 32'h1);
    check("err_valid", {31'h0, pc_valid}, 32'h0);
    check("err_misal", {31'h0, misalign_trap}, 32'h0);
    check("err_fcnt", {24'h0, fault_count}, 32'hFF);

    // Reset wins over a pending misaligned redirect and clears ERROR.
    reset = 1'b1;
    trap_req     = 1'b0;
    fault_inject = 3'b000;
    step();
    check("rerst_pc", pc, 32'h0);
    check("rerst_uncorr", {31'h0, uncorrectable}, 32'h0);
    check("rerst_valid", {31'h0, pc_valid}, 32'h0);
    check("rerst_misal", {31'h0, misalign_trap}, 32'h0);
    check("rerst_fcnt", {24'h0, fault_count}, 32'h0);
    reset = 1'b0;
    idle_inputs();
    step();
    check("rerun_pc", pc, 32'h4);
    check("rerun_valid", {31'h0, pc_valid}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
